// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between the instruction and data miss paths.
// Single outstanding transaction; data wins unless instruction fetch has starved.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;  // 1 = data side owns the transaction
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        grant_d, grant_i;

    logic        m_wr_q, m_wr_d;
    logic [2:0]  m_size_q, m_size_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
            m_wr_q       <= 1'b0;
            m_size_q     <= 3'd0;
            m_wstrb_q    <= 4'd0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            m_wr_q       <= m_wr_d;
            m_size_q     <= m_size_d;
            m_wstrb_q    <= m_wstrb_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    // Arbitration is only meaningful in IDLE
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == StIdle) begin
            grant_d = d_req && !(i_req && (starve_cnt_q == StarveLimit));
            grant_i = i_req && !grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        m_wr_d       = m_wr_q;
        m_size_d     = m_size_q;
        m_wstrb_d    = m_wstrb_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d   = StAddr;
                    owner_d   = 1'b1;
                    m_wr_d    = d_wr;
                    m_size_d  = d_size;
                    m_wstrb_d = d_wstrb;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    if (!i_req) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q < StarveLimit) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (grant_i) begin
                    state_d      = StAddr;
                    owner_d      = 1'b0;
                    m_wr_d       = 1'b0;
                    m_size_d     = i_size;
                    m_wstrb_d    = 4'd0;
                    m_addr_d     = i_addr;
                    starve_cnt_d = 4'd0;
                end
            end
            StAddr: begin
                if (m_addr_ok) state_d = StData;
            end
            StData: begin
                if (m_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        i_addr_ok = grant_i && !reset;
        d_addr_ok = grant_d && !reset;
        i_data_ok = (state_q == StData) && !owner_q && m_data_ok && !reset;
        d_data_ok = (state_q == StData) && owner_q && m_data_ok && !reset;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
        m_req     = (state_q == StAddr);
        m_wr      = m_wr_q;
        m_size    = m_size_q;
        m_wstrb   = m_wstrb_q;
        m_addr    = m_addr_q;
        m_wdata   = m_wdata_q;
    end

endmodule
